// File: rtl/uart_tx_arbiter_if.sv
// Producer-side handshake bundle for the shared UART transmitter.
// Byte of requester i travels on req_data[8*i+7:8*i].
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;

   modport master (
      output req_valid,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single 8N1 UART transmitter.
// One byte is accepted per frame; the line idles high between frames.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int CLKS_PER_BIT = 234,
   parameter int SRC_W        = $clog2(NUM_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   uart_tx_arbiter_if.slave req,
   output logic             tx,
   output logic             busy,
   output logic [SRC_W-1:0] cur_src
);
   localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [SRC_W-1:0] LAST_INIT = SRC_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic [2:0]       bit_idx_reg;
   logic [7:0]       shift_reg;
   logic [SRC_W-1:0] last_reg;
   logic [SRC_W-1:0] cur_src_reg;
   logic             tx_reg;
   logic             busy_reg;

   logic             bit_done;
   logic             grant_ok;
   logic [SRC_W-1:0] winner;
   logic [7:0]       req_byte [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_byte[gi] = req.req_data[8*gi +: 8];
   end

   assign bit_done = (cnt_reg == CNT_MAX);
   assign cnt_next = bit_done ? '0 : cnt_reg + 1'b1;

   // Walk the ring from the far end back toward last+1 so the nearest valid
   // requester after the previous winner is the one left standing.
   always_comb begin
      int               idx;
      logic [SRC_W-1:0] idx_s;
      grant_ok = 1'b0;
      winner   = last_reg;
      idx      = 0;
      idx_s    = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx   = (int'(last_reg) + k) % NUM_REQ;
         idx_s = SRC_W'(idx);
         if (req.req_valid[idx_s]) begin
            grant_ok = 1'b1;
            winner   = idx_s;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (en && grant_ok) state_next = START;
         START: if (bit_done) state_next = DATA;
         DATA:  if (bit_done && bit_idx_reg == 3'd7) state_next = STOP;
         STOP:  if (bit_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req.req_ready = '0;
      if (rst_n && state_reg == IDLE && en && grant_ok) begin
         req.req_ready[winner] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg     <= '0;
         bit_idx_reg <= 3'd0;
         shift_reg   <= 8'd0;
         last_reg    <= LAST_INIT;
         cur_src_reg <= '0;
         tx_reg      <= 1'b1;
         busy_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               cnt_reg <= '0;
               if (en && grant_ok) begin
                  shift_reg   <= req_byte[winner];
                  last_reg    <= winner;
                  cur_src_reg <= winner;
                  tx_reg      <= 1'b0;
                  busy_reg    <= 1'b1;
               end
            end
            START: begin
               cnt_reg <= cnt_next;
               if (bit_done) begin
                  tx_reg      <= shift_reg[0];
                  shift_reg   <= {1'b0, shift_reg[7:1]};
                  bit_idx_reg <= 3'd0;
               end
            end
            DATA: begin
               cnt_reg <= cnt_next;
               if (bit_done) begin
                  if (bit_idx_reg == 3'd7) begin
                     tx_reg <= 1'b1;
                  end else begin
                     tx_reg      <= shift_reg[0];
                     shift_reg   <= {1'b0, shift_reg[7:1]};
                     bit_idx_reg <= bit_idx_reg + 3'd1;
                  end
               end
            end
            STOP: begin
               cnt_reg <= cnt_next;
               if (bit_done) busy_reg <= 1'b0;
            end
            default: cnt_reg <= '0;
         endcase
      end
   end

   assign tx      = tx_reg;
   assign busy    = busy_reg;
   assign cur_src = cur_src_reg;
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one 8N1 UART transmit line between `NUM_REQ` byte producers. Each producer offers bytes over a valid/ready handshake. The block grants the line round-robin, serializes the accepted byte at `CLKS_PER_BIT` clocks per bit, and drives the pin idle-high between frames. It sits between on-chip sources (status, debug, data streams) and the board's serial TX pin.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters; ≥2.
- `CLKS_PER_BIT`, default 234: clocks per bit (27 MHz / 115200); ≥2.
- `SRC_W`, default `$clog2(NUM_REQ)`: width of `cur_src`.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `en`  in  1: when high, new grants are allowed; an in-flight frame always completes.
- `req_valid`  in  `NUM_REQ`: bit i high means requester i offers a byte.
- `req_data`  in  `8*NUM_REQ`: byte of requester i is at `[8*i+7:8*i]`.
- `req_ready`  out  `NUM_REQ`: one-hot or zero; bit i high means requester i's byte is accepted this cycle.
- `tx`  out  1: serial line, registered, idle high.
- `busy`  out  1: registered; high from the cycle after acceptance until the frame ends.
- `cur_src`  out  `SRC_W`: registered index of the requester owning the current or last frame.

## Operation

- **States:** IDLE, START, DATA, STOP.
- **Frame format:** start bit 0, then `data[0]`..`data[7]` LSB first, then stop bit 1. Each bit holds for `CLKS_PER_BIT` cycles.
- **IDLE**
  - `tx`=1, `busy`=0.
  - If `en` and any `req_valid`, select the winner by round-robin.
  - Search order is `last+1`, `last+2`, … modulo `NUM_REQ`, where `last` is the previously granted index.
  - `req_ready[winner]`=1 combinationally in that cycle. This is the transfer cycle.
  - On the edge ending the transfer cycle: latch `req_data[winner]` into the shift register, set `last`=`cur_src`=winner, `tx`←0, `busy`←1, clear the baud counter, and go to START.
- **START:** after `CLKS_PER_BIT` cycles, `tx`←bit0, bit index←0, go to DATA.
- **DATA**
  - Every `CLKS_PER_BIT` cycles, advance to the next bit.
  - After bit 7 completes, `tx`←1 and go to STOP.
- **STOP:** after `CLKS_PER_BIT` cycles, `busy`←0 and go to IDLE.
- **Handshake rules**
  - A requester must hold `req_valid` and `req_data` stable until it sees `req_ready`. It may not retract an offer.
  - `req_ready` is 0 in every state other than IDLE, and whenever `en`=0.
  - `req_ready` may depend combinationally on `req_valid`; it never depends on `req_data`.
- **Counters**
  - The baud counter is `$clog2(CLKS_PER_BIT)` bits, counts 0..`CLKS_PER_BIT`-1, and wraps.
  - The bit index is 3 bits.
  - No other arithmetic.
- **Boundary conditions**
  - `en` falling mid-frame: the frame finishes normally and no new grant follows.
  - `en` rising in IDLE with requests pending: grant in that same cycle.
  - A single requester valid continuously: it wins every frame.
  - All requesters valid: grants rotate 0,1,2,3,0,… after reset.
  - `req_valid` of a non-winner changing during a frame has no effect.
  - Reset asserted mid-frame: immediately `tx`=1, `busy`=0, `req_ready`=0, state IDLE, `cur_src`=0, `last`=`NUM_REQ`-1. The partial frame is abandoned.

## Timing

- **Reset values:** `tx`=1, `busy`=0, `req_ready`=0, `cur_src`=0. After reset, requester 0 has highest priority.
- **Frame start:** `tx` falls on the first edge after the transfer cycle T, and the start bit occupies cycles T+1..T+`CLKS_PER_BIT`.
- **Data bit k:** occupies cycles T+1+(k+1)·`CLKS_PER_BIT` through T+(k+2)·`CLKS_PER_BIT`.
- **Stop bit:** ends at cycle T+10·`CLKS_PER_BIT`. The state is IDLE at T+10·`CLKS_PER_BIT`+1.
- **Back-to-back frames:** the earliest next transfer cycle is T+10·`CLKS_PER_BIT`+1. The repetition period is therefore 10·`CLKS_PER_BIT`+1 cycles, with `tx`=1 for that one extra cycle.
- **`busy`:** high exactly for cycles T+1..T+10·`CLKS_PER_BIT`.

## Test plan

Use `CLKS_PER_BIT`=4 and `NUM_REQ`=4 for all directed tests.

1. **Single byte:** requester 2 offers 0xA5 → `req_ready`=4'b0100 for 1 cycle. `tx` is 0×4, then 1,0,1,0,0,1,0,1 ×4 each, then 1×4. `busy` is high for 40 cycles. `cur_src`=2.
2. **Round-robin:** all four valid with bytes 0x10..0x13 → frames sent in order 0,1,2,3, periods of 41 cycles, `req_ready` never multi-hot.
3. **Fairness after a grant:** requester 1 granted, then requesters 1 and 3 valid → 3 wins next, then 1.
4. **Enable gating:** `en`=0 with requester 0 valid → no `req_ready`, `tx` stays 1. Raise `en` → grant in the same cycle. Drop `en` mid-frame → the frame completes and no further grant.
5. **Reset mid-frame:** assert `rst_n`=0 during DATA bit 3 → `tx`=1, `busy`=0 asynchronously. After release with requesters 0 and 3 valid → requester 0 granted first.
6. **Stream hold:** requester 1 holds valid over three bytes, changing data only after each `req_ready` (0x00, 0xFF, 0x3C) → three exact frames, each separated by one idle-high cycle.
